// File: rtl/control_puerta_if.sv
// Signal bundle between the elevator algorithm/cabin side and the door controller.
interface control_puerta_if;
   logic       abrir;
   logic [1:0] motor;
   logic       boton_abrir;
   logic       boton_cerrar;
   logic       obstruccion;
   logic       esperar;
   logic [1:0] actuador;
   logic [1:0] estado_puerta;
   logic       error_seguridad;

   modport master (
      output abrir, motor, boton_abrir, boton_cerrar, obstruccion,
      input  esperar, actuador, estado_puerta, error_seguridad
   );

   modport slave (
      input  abrir, motor, boton_abrir, boton_cerrar, obstruccion,
      output esperar, actuador, estado_puerta, error_seguridad
   );
endinterface

// File: rtl/control_puerta.sv
// Elevator door controller: timed open/dwell/close sequence with motor interlock.
// Define PUERTA_OBSTRUCCION_EN to let the edge sensor reload the dwell and reopen a closing door.
module control_puerta #(
   parameter int unsigned T_MOV    = 4,
   parameter int unsigned T_ESPERA = 20
) (
   input  logic              clk,
   input  logic              reset,
   control_puerta_if.slave   bus
);

   typedef enum logic [1:0] {
      CERRADA  = 2'b00,
      ABRIENDO = 2'b01,
      ABIERTA  = 2'b10,
      CERRANDO = 2'b11
   } estado_t;

   localparam logic [7:0] C_MOV = 8'(T_MOV - 1);
   localparam logic [7:0] C_ESP = 8'(T_ESPERA - 1);

   estado_t    r_estado;
   estado_t    w_estado_sig;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_sig;
   logic       r_esperar;
   logic [1:0] r_actuador;
   logic [1:0] w_actuador_sig;
   logic       r_error;
   logic       w_obs;
   logic       w_mov;
   logic       w_recarga;

`ifdef PUERTA_OBSTRUCCION_EN
   assign w_obs = bus.obstruccion;
`else
   assign w_obs = 1'b0 & bus.obstruccion;
`endif

   assign w_mov     = (bus.motor != 2'b00);
   assign w_recarga = bus.abrir | bus.boton_abrir | w_obs;

   always_comb begin
      w_estado_sig = r_estado;
      w_cnt_sig    = r_cnt - 8'd1;
      case (r_estado)
         CERRADA: begin
            w_cnt_sig = r_cnt;
            if (!w_mov && (bus.abrir || bus.boton_abrir)) begin
               w_estado_sig = ABRIENDO;
               w_cnt_sig    = C_MOV;
            end
         end
         ABRIENDO: begin
            if (r_cnt == 8'd0) begin
               w_estado_sig = ABIERTA;
               w_cnt_sig    = C_ESP;
            end
         end
         ABIERTA: begin
            // Reload sources take priority over the close button.
            if (w_recarga) begin
               w_cnt_sig = C_ESP;
            end else if (bus.boton_cerrar || r_cnt == 8'd0) begin
               w_estado_sig = CERRANDO;
               w_cnt_sig    = C_MOV;
            end
         end
         CERRANDO: begin
            if (bus.boton_abrir || w_obs) begin
               w_estado_sig = ABRIENDO;
               w_cnt_sig    = C_MOV;
            end else if (r_cnt == 8'd0) begin
               w_estado_sig = CERRADA;
               w_cnt_sig    = '0;
            end
         end
         default: begin
            w_estado_sig = CERRADA;
            w_cnt_sig    = '0;
         end
      endcase

      w_actuador_sig = 2'b00;
      case (w_estado_sig)
         ABRIENDO: w_actuador_sig = 2'b01;
         CERRANDO: w_actuador_sig = 2'b10;
         default:  w_actuador_sig = 2'b00;
      endcase
   end

   // Outputs are registered from the next state so they track r_estado exactly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_estado   <= CERRADA;
         r_cnt      <= '0;
         r_esperar  <= 1'b0;
         r_actuador <= 2'b00;
         r_error    <= 1'b0;
      end else begin
         r_estado   <= w_estado_sig;
         r_cnt      <= w_cnt_sig;
         r_esperar  <= (w_estado_sig != CERRADA);
         r_actuador <= w_actuador_sig;
         r_error    <= r_error | (w_mov && (r_estado != CERRADA));
      end
   end

   assign bus.esperar         = r_esperar;
   assign bus.actuador        = r_actuador;
   assign bus.estado_puerta   = r_estado;
   assign bus.error_seguridad = r_error;

endmodule

// File: tb/tb_control_puerta.sv
// Self-checking bench for control_puerta: directed scenarios plus random stimulus against a phase/time-left model.
module tb_control_puerta;

   localparam int unsigned TM = 4;
   localparam int unsigned TE = 20;
`ifdef PUERTA_OBSTRUCCION_EN
   localparam bit OBS_EN = 1'b1;
`else
   localparam bit OBS_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;

   control_puerta_if bus();

   control_puerta #(.T_MOV(TM), .T_ESPERA(TE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Model: phase 0 closed, 1 opening, 2 open, 3 closing; left = cycles remaining in phase.
   int m_ph   = 0;
   int m_left = 0;
   bit m_err  = 1'b0;

   int c_esp, c_op, c_cl, c_open;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [5:0] model_outs();
      logic [1:0] a;
      a = (m_ph == 1) ? 2'b01 : (m_ph == 3) ? 2'b10 : 2'b00;
      return {(m_ph != 0), a, 2'(m_ph), m_err};
   endfunction

   function automatic logic [5:0] dut_outs();
      return {bus.esperar, bus.actuador, bus.estado_puerta, bus.error_seguridad};
   endfunction

   task automatic model_edge();
      bit obs_act;
      obs_act = OBS_EN && bus.obstruccion;
      if (bus.motor != 2'b00 && m_ph != 0) m_err = 1'b1;
      case (m_ph)
         0: if (bus.motor == 2'b00 && (bus.abrir || bus.boton_abrir)) begin
               m_ph = 1; m_left = TM;
            end
         1: if (m_left == 1) begin m_ph = 2; m_left = TE; end
            else m_left--;
         2: if (bus.abrir || bus.boton_abrir || obs_act) m_left = TE;
            else if (bus.boton_cerrar || m_left == 1) begin m_ph = 3; m_left = TM; end
            else m_left--;
         default: if (bus.boton_abrir || obs_act) begin m_ph = 1; m_left = TM; end
            else if (m_left == 1) m_ph = 0;
            else m_left--;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("outs", dut_outs(), model_outs());
      if (bus.esperar) c_esp++;
      if (bus.actuador == 2'b01) c_op++;
      if (bus.actuador == 2'b10) c_cl++;
      if (bus.estado_puerta == 2'b10) c_open++;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic clr();
      c_esp = 0; c_op = 0; c_cl = 0; c_open = 0;
   endtask

   task automatic idle();
      bus.abrir = 1'b0; bus.motor = 2'b00; bus.boton_abrir = 1'b0;
      bus.boton_cerrar = 1'b0; bus.obstruccion = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_async", dut_outs(), 6'b0);
      m_ph = 0; m_left = 0; m_err = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_hold", dut_outs(), 6'b0);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      idle();
      #1;
      chk("reset_state", dut_outs(), 6'b0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      step();

      // Full open/dwell/close cycle from a one-cycle abrir pulse
      clr();
      bus.abrir = 1'b1; step(); bus.abrir = 1'b0;
      steps(40);
      chk("cycle_esperar", c_esp, 28);
      chk("cycle_abriendo", c_op, 4);
      chk("cycle_abierta", c_open, 20);
      chk("cycle_cerrando", c_cl, 4);

      // Close button during the fourth open cycle
      clr();
      bus.abrir = 1'b1; step(); bus.abrir = 1'b0;
      steps(7);
      bus.boton_cerrar = 1'b1; step(); bus.boton_cerrar = 1'b0;
      steps(20);
      chk("cerrar_esperar", c_esp, 12);
      chk("cerrar_abierta", c_open, 4);

      // Obstruction while closing
      clr();
      bus.abrir = 1'b1; step(); bus.abrir = 1'b0;
      steps(25);
      chk("obs_pre_state", bus.estado_puerta, 2'b11);
      bus.obstruccion = 1'b1; step(); bus.obstruccion = 1'b0;
      steps(60);
      chk("obs_esperar", c_esp, OBS_EN ? 54 : 28);
      chk("obs_abriendo", c_op, OBS_EN ? 8 : 4);

      // Interlock: motor running blocks opening; motor during open sets sticky error
      clr();
      bus.motor = 2'b01; bus.abrir = 1'b1;
      steps(5);
      chk("lock_esperar", c_esp, 0);
      chk("lock_state", bus.estado_puerta, 2'b00);
      idle(); step();
      bus.abrir = 1'b1; step(); bus.abrir = 1'b0;
      steps(6);
      chk("lock_open", bus.estado_puerta, 2'b10);
      bus.motor = 2'b10; step(); bus.motor = 2'b00;
      chk("err_set", bus.error_seguridad, 1'b1);
      steps(40);
      chk("err_sticky", bus.error_seguridad, 1'b1);
      chk("err_closed", bus.estado_puerta, 2'b00);
      do_reset();

      // Asynchronous reset in the middle of opening
      bus.abrir = 1'b1; step(); bus.abrir = 1'b0;
      step();
      chk("mid_open_state", bus.actuador, 2'b01);
      #2;
      do_reset();
      clr();
      steps(10);
      chk("post_rst_esperar", c_esp, 0);

      // Dwell extension while abrir is held
      bus.abrir = 1'b1; step(); bus.abrir = 1'b0;
      steps(4);
      bus.abrir = 1'b1; steps(30); bus.abrir = 1'b0;
      c_open = (bus.estado_puerta == 2'b10) ? 1 : 0;
      steps(40);
      chk("dwell_open", c_open, 20);

      // Random stimulus against the model
      for (int i = 0; i < 800; i++) begin
         if (i % 200 == 199) begin
            idle();
            do_reset();
         end else begin
            bus.abrir        = ($urandom_range(0, 9) == 0);
            bus.boton_abrir  = ($urandom_range(0, 11) == 0);
            bus.boton_cerrar = ($urandom_range(0, 7) == 0);
            bus.obstruccion  = ($urandom_range(0, 9) == 0);
            bus.motor        = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step();
         end
      end

      idle();
      steps(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/control_puerta.md
CONTROL_PUERTA -- requirements
Module: control_puerta

Interface
REQ-001 Parameter T_MOV, default 4, door travel time in clock cycles (open or close), legal 1..255, SHALL be honoured.
REQ-002 Parameter T_ESPERA, default 20, dwell time with door fully open in cycles, legal 1..255, SHALL be honoured.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1, the system clock.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port abrir, input, 1, open request from the algorithm block on arrival at a requested floor (level).
REQ-007 Port motor, input, 2, motor command from the algorithm block; 00 = stopped.
REQ-008 Port boton_abrir, input, 1, cabin "open door" button (level).
REQ-009 Port boton_cerrar, input, 1, cabin "close door" button (level).
REQ-010 Port obstruccion, input, 1, door-edge obstruction sensor (level).
REQ-011 Port esperar, output, 1, hold request to the algorithm block; high whenever the door is not closed.
REQ-012 Port actuador, output, 2, door drive: 00 idle, 01 open, 10 close.
REQ-013 Port estado_puerta, output, 2, current state encoding.
REQ-014 Port error_seguridad, output, 1, sticky flag: motor moved while the door was not closed.

Function
REQ-015 The FSM SHALL have states CERRADA=00, ABRIENDO=01, ABIERTA=10, CERRANDO=11; estado_puerta SHALL equal the state register.
REQ-016 An 8-bit down-counter SHALL time ABRIENDO, ABIERTA and CERRANDO; the state exits on the cycle the counter is 0.
REQ-017 CERRADA: if motor==00 and (abrir or boton_abrir), next state ABRIENDO with counter=T_MOV-1; otherwise remain.
REQ-018 CERRADA with motor!=00: abrir and boton_abrir SHALL be ignored.
REQ-019 ABRIENDO: actuador=01; on counter==0, next state ABIERTA with counter=T_ESPERA-1.
REQ-020 ABIERTA: actuador=00; abrir, boton_abrir or obstruccion (when enabled) SHALL reload counter=T_ESPERA-1 and keep ABIERTA.
REQ-021 ABIERTA: boton_cerrar with no reload source active SHALL go to CERRANDO next cycle with counter=T_MOV-1; a reload source wins over boton_cerrar.
REQ-022 ABIERTA: on counter==0 with no reload source, next state CERRANDO with counter=T_MOV-1.
REQ-023 CERRANDO: actuador=10; boton_abrir or obstruccion (when enabled) SHALL go to ABRIENDO with counter=T_MOV-1; otherwise, on counter==0, next state CERRADA.
REQ-024 esperar SHALL be decoded from the registered state (state!=CERRADA), with no combinational path from any input.
REQ-025 actuador SHALL be decoded from the registered state only.
REQ-026 error_seguridad SHALL set on any clock edge where motor!=00 and state!=CERRADA, and SHALL hold until reset.
REQ-027 Simultaneous abrir and boton_cerrar in CERRADA SHALL open the door (boton_cerrar is ignored in CERRADA).

Reset
REQ-028 Reset SHALL force state CERRADA, counter 0, esperar=0, actuador=00, estado_puerta=00 and error_seguridad=0, immediately and independent of clk.
REQ-029 Reset asserted mid-travel (ABRIENDO or CERRANDO) SHALL return to CERRADA with no intermediate actuador value after deassertion.
REQ-030 After reset deasserts, the first state change SHALL occur on the next rising clk edge.

Configuration
REQ-031 With macro PUERTA_OBSTRUCCION_EN defined, obstruccion SHALL act as specified in REQ-020 and REQ-023.
REQ-032 Without PUERTA_OBSTRUCCION_EN, obstruccion SHALL be ignored, and only boton_abrir SHALL reopen a closing door.

Verification
REQ-033 Open and close cycle: T_MOV=4, T_ESPERA=20, motor=00, one-cycle abrir pulse -> actuador=01 for 4 cycles, ABIERTA for 20 cycles, actuador=10 for 4 cycles, then CERRADA; esperar high for exactly 28 cycles.
REQ-034 Close button: boton_cerrar asserted at cycle 3 of ABIERTA -> CERRANDO on the next cycle, and total esperar time is 4+4+4 cycles.
REQ-035 Obstruction: obstruccion pulsed at cycle 2 of CERRANDO -> ABRIENDO for 4 cycles, then a full 20-cycle ABIERTA; without PUERTA_OBSTRUCCION_EN, closing completes unchanged.
REQ-036 Interlock: abrir=1 with motor=01 in CERRADA -> the door stays CERRADA and esperar=0; forcing motor=10 during ABIERTA -> error_seguridad=1 and it persists until reset.
REQ-037 Reset mid-ABRIENDO (cycle 2) -> all outputs 0 asynchronously, and the door stays CERRADA after release until the next abrir.
REQ-038 Dwell extension: abrir held for 30 cycles during ABIERTA -> the door remains open until 20 cycles after abrir falls.
